// File: rtl/vec_issue_ctrl.sv
// Vector instruction issue controller: instruction FIFO, single-issue
// sequencer towards the vector core, one-entry read result buffer.
module vec_issue_ctrl #(
    parameter int els_p         = 8,
    parameter int vlen_p        = 4,
    parameter int vdw_p         = 4,
    parameter int fifo_els_p    = 4,
    parameter int count_width_p = 16,
    localparam int addr_w = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int data_w = vlen_p * vdw_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     instr_v_i,
    output logic                     instr_ready_o,
    input  logic [3:0]               instr_op_i,
    input  logic [addr_w-1:0]        instr_addrA_i,
    input  logic [addr_w-1:0]        instr_addrB_i,
    input  logic [addr_w-1:0]        instr_addrC_i,
    input  logic [data_w-1:0]        instr_scalar_i,
    input  logic [data_w-1:0]        instr_wdata_i,
    output logic                     vec_v_o,
    input  logic                     vec_ready_i,
    output logic [3:0]               vec_op_o,
    output logic [addr_w-1:0]        vec_addrA_o,
    output logic [addr_w-1:0]        vec_addrB_o,
    output logic [addr_w-1:0]        vec_addrC_o,
    output logic [data_w-1:0]        vec_scalar_o,
    output logic [data_w-1:0]        vec_wdata_o,
    input  logic                     vec_done_i,
    input  logic                     vec_v_i,
    input  logic [data_w-1:0]        vec_rdata_i,
    output logic                     vec_yumi_o,
    output logic                     res_v_o,
    output logic [data_w-1:0]        res_data_o,
    output logic [addr_w-1:0]        res_addr_o,
    input  logic                     res_yumi_i,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [count_width_p-1:0] done_count_o
);

    localparam int ptr_w = $clog2(fifo_els_p);

    typedef struct packed {
        logic [3:0]        op;
        logic [addr_w-1:0] a;
        logic [addr_w-1:0] b;
        logic [addr_w-1:0] c;
        logic [data_w-1:0] s;
        logic [data_w-1:0] w;
    } instr_t;

    typedef enum logic {IDLE, WAIT} state_e;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        unique case (1'b1)
            op[3]:   ok = (op[2:1] == 2'b00);
            default: ok = (op[1:0] != 2'b11);
        endcase
        return ok;
    endfunction

    instr_t           mem [fifo_els_p];
    logic [ptr_w:0]   wptr;
    logic [ptr_w:0]   rptr;
    logic             empty;
    logic             full;
    logic             enq;
    logic             pop;
    instr_t           head;
    logic             head_legal;

    state_e            state;
    logic              is_read;
    logic [addr_w-1:0] rd_addr;
    logic              rd_got;
    logic              done_got;
    logic              hs;
    logic              complete;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ptr_w] != rptr[ptr_w])
                 && (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]);
    assign enq   = instr_v_i & ~full;
    assign head  = mem[rptr[ptr_w-1:0]];
    assign head_legal = op_legal(head.op);

    assign instr_ready_o = ~full;

    assign pop = (state == IDLE) & ~empty
               & (~head_legal | vec_ready_i);

    assign vec_v_o      = (state == IDLE) & ~empty & head_legal;
    assign vec_op_o     = head.op;
    assign vec_addrA_o  = head.a;
    assign vec_addrB_o  = head.b;
    assign vec_addrC_o  = head.c;
    assign vec_scalar_o = head.s;
    assign vec_wdata_o  = head.w;

    assign hs = (state == WAIT) & is_read & vec_v_i
              & ~rd_got & ~res_v_o;
    assign vec_yumi_o = hs;

    assign complete = (state == WAIT)
                    & (done_got | vec_done_i)
                    & (~is_read | rd_got | hs);

    assign busy_o = ~empty | (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr[ptr_w-1:0]] <= '{
                op: instr_op_i,
                a:  instr_addrA_i,
                b:  instr_addrB_i,
                c:  instr_addrC_i,
                s:  instr_scalar_i,
                w:  instr_wdata_i
            };
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            is_read      <= 1'b0;
            rd_addr      <= '0;
            rd_got       <= 1'b0;
            done_got     <= 1'b0;
            err_o        <= 1'b0;
            res_v_o      <= 1'b0;
            res_data_o   <= '0;
            res_addr_o   <= '0;
            done_count_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop & head_legal) begin
                        state    <= WAIT;
                        is_read  <= (head.op == 4'b1000);
                        rd_addr  <= head.a;
                        rd_got   <= 1'b0;
                        done_got <= 1'b0;
                    end
                end
                WAIT: begin
                    if (hs) rd_got <= 1'b1;
                    if (vec_done_i) done_got <= 1'b1;
                    if (complete) begin
                        state        <= IDLE;
                        done_count_o <= done_count_o + 1'b1;
                    end
                end
            endcase
            if (pop & ~head_legal) err_o <= 1'b1;
            // A new capture can only happen while the buffer is empty.
            if (hs) begin
                res_v_o    <= 1'b1;
                res_data_o <= vec_rdata_i;
                res_addr_o <= rd_addr;
            end else if (res_yumi_i) begin
                res_v_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Bench for vec_issue_ctrl: core model, transaction-level reference
// model checked every cycle, and directed scenarios with literal results.
module tb_vec_issue_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          instr_v_i;
    logic          instr_ready_o;
    logic [3:0]    instr_op_i;
    logic [AW-1:0] instr_addrA_i, instr_addrB_i, instr_addrC_i;
    logic [DW-1:0] instr_scalar_i, instr_wdata_i;
    logic          vec_v_o;
    logic          vec_ready_i;
    logic [3:0]    vec_op_o;
    logic [AW-1:0] vec_addrA_o, vec_addrB_o, vec_addrC_o;
    logic [DW-1:0] vec_scalar_o, vec_wdata_o;
    logic          vec_done_i;
    logic          vec_v_i;
    logic [DW-1:0] vec_rdata_i;
    logic          vec_yumi_o;
    logic          res_v_o;
    logic [DW-1:0] res_data_o;
    logic [AW-1:0] res_addr_o;
    logic          res_yumi_i;
    logic          busy_o;
    logic          err_o;
    logic [15:0]   done_count_o;

    always #5 clk = ~clk;

    vec_issue_ctrl #(
        .els_p(8), .vlen_p(4), .vdw_p(4),
        .fifo_els_p(4), .count_width_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .instr_v_i(instr_v_i), .instr_ready_o(instr_ready_o),
        .instr_op_i(instr_op_i),
        .instr_addrA_i(instr_addrA_i),
        .instr_addrB_i(instr_addrB_i),
        .instr_addrC_i(instr_addrC_i),
        .instr_scalar_i(instr_scalar_i),
        .instr_wdata_i(instr_wdata_i),
        .vec_v_o(vec_v_o), .vec_ready_i(vec_ready_i),
        .vec_op_o(vec_op_o),
        .vec_addrA_o(vec_addrA_o),
        .vec_addrB_o(vec_addrB_o),
        .vec_addrC_o(vec_addrC_o),
        .vec_scalar_o(vec_scalar_o),
        .vec_wdata_o(vec_wdata_o),
        .vec_done_i(vec_done_i), .vec_v_i(vec_v_i),
        .vec_rdata_i(vec_rdata_i), .vec_yumi_o(vec_yumi_o),
        .res_v_o(res_v_o), .res_data_o(res_data_o),
        .res_addr_o(res_addr_o), .res_yumi_i(res_yumi_i),
        .busy_o(busy_o), .err_o(err_o),
        .done_count_o(done_count_o)
    );

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] a, b, c;
        logic [DW-1:0] s, w;
    } ins_t;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    int done_dly = 1;
    int rd_dly = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] op);
        return op == 4'b1000 || op == 4'b1001
            || (op[3] == 1'b0 && op[1:0] != 2'b11);
    endfunction

    function automatic logic [DW-1:0] alu(input logic [1:0] f,
        input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] r;
        logic [3:0] p, q;
        r = '0;
        for (int e = 0; e < 4; e++) begin
            p = x[e*4 +: 4];
            q = y[e*4 +: 4];
            case (f)
                2'b00:   r[e*4 +: 4] = p + q;
                2'b01:   r[e*4 +: 4] = p - q;
                default: r[e*4 +: 4] = p * q;
            endcase
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] result(input ins_t i,
        input logic [DW-1:0] ra, input logic [DW-1:0] rb);
        if (i.op == 4'b1001) return i.w;
        if (i.op[2]) return alu(i.op[1:0], ra, i.s);
        return alu(i.op[1:0], ra, rb);
    endfunction

    // Core model: executes accepted instructions, replies after delays.
    logic [DW-1:0] crf [8];
    initial begin
        bit acc, yhs, rst;
        ins_t ci;
        int dcnt, rcnt;
        logic [DW-1:0] rv;
        dcnt = -1; rcnt = -1; rv = '0;
        for (int i = 0; i < 8; i++) crf[i] = '0;
        vec_done_i = 0; vec_v_i = 0; vec_rdata_i = '0;
        forever begin
            @(negedge clk);
            rst = reset_i;
            acc = (vec_v_o === 1'b1) && vec_ready_i && !reset_i;
            yhs = (vec_yumi_o === 1'b1) && vec_v_i;
            if (acc) begin
                ci.op = vec_op_o; ci.a = vec_addrA_o;
                ci.b = vec_addrB_o; ci.c = vec_addrC_o;
                ci.s = vec_scalar_o; ci.w = vec_wdata_o;
            end
            @(posedge clk);
            #1;
            vec_done_i = 0;
            if (yhs || rst) begin vec_v_i = 0; rcnt = -1; end
            if (acc) begin
                rv = crf[ci.a];
                if (ci.op != 4'b1000)
                    crf[ci.c] = result(ci, crf[ci.a], crf[ci.b]);
                dcnt = done_dly;
                rcnt = (ci.op == 4'b1000) ? rd_dly : -1;
            end
            if (dcnt == 0) vec_done_i = 1;
            if (dcnt >= 0) dcnt--;
            if (rcnt == 0) begin vec_v_i = 1; vec_rdata_i = rv; end
            if (rcnt >= 0) rcnt--;
        end
    end

    // Reference model: queue of pending instructions plus one in flight.
    ins_t mq[$];
    logic [DW-1:0] mrf [8];
    initial begin
        ins_t f, n;
        bit infl, m_rd, m_rdgot, m_dgot, m_err, m_resv;
        bit enq, exp_vv, exp_y;
        logic [DW-1:0] m_rdata, m_cur_rd;
        logic [AW-1:0] m_raddr, m_cur_a;
        logic [15:0] m_cnt;
        infl = 0; m_rd = 0; m_rdgot = 0; m_dgot = 0;
        m_err = 0; m_resv = 0; m_cnt = '0;
        m_rdata = '0; m_raddr = '0; m_cur_rd = '0; m_cur_a = '0;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        forever begin
            @(negedge clk);
            if (!started) continue;
            enq = instr_v_i && mq.size() < 4;
            chk("instr_ready", instr_ready_o, mq.size() < 4);
            chk("busy", busy_o, mq.size() != 0 || infl);
            exp_vv = !infl && mq.size() != 0 && legal(mq[0].op);
            chk("vec_v", vec_v_o, exp_vv);
            if (exp_vv) begin
                chk("vec_op", vec_op_o, mq[0].op);
                chk("vec_addrA", vec_addrA_o, mq[0].a);
                chk("vec_addrB", vec_addrB_o, mq[0].b);
                chk("vec_addrC", vec_addrC_o, mq[0].c);
                chk("vec_scalar", vec_scalar_o, mq[0].s);
                chk("vec_wdata", vec_wdata_o, mq[0].w);
            end
            chk("err", err_o, m_err);
            chk("done_count", done_count_o, m_cnt);
            chk("res_v", res_v_o, m_resv);
            if (m_resv) begin
                chk("res_data", res_data_o, m_rdata);
                chk("res_addr", res_addr_o, m_raddr);
            end
            exp_y = infl && m_rd && vec_v_i && !m_rdgot && !m_resv;
            chk("vec_yumi", vec_yumi_o, exp_y);
            if (reset_i) begin
                mq.delete();
                infl = 0; m_err = 0; m_resv = 0; m_cnt = '0;
                continue;
            end
            if (m_resv && res_yumi_i) m_resv = 0;
            if (infl) begin
                if (exp_y) begin
                    m_resv = 1; m_rdata = m_cur_rd;
                    m_raddr = m_cur_a; m_rdgot = 1;
                end
                if (vec_done_i) m_dgot = 1;
                if (m_dgot && (!m_rd || m_rdgot)) begin
                    m_cnt = m_cnt + 1'b1;
                    infl = 0;
                end
            end else if (mq.size() != 0) begin
                f = mq[0];
                if (!legal(f.op)) begin
                    void'(mq.pop_front());
                    m_err = 1;
                end else if (vec_ready_i) begin
                    void'(mq.pop_front());
                    infl = 1; m_rdgot = 0; m_dgot = 0;
                    m_rd = (f.op == 4'b1000);
                    m_cur_a = f.a;
                    m_cur_rd = mrf[f.a];
                    if (f.op != 4'b1000)
                        mrf[f.c] = result(f, mrf[f.a], mrf[f.b]);
                end
            end
            if (enq) begin
                n.op = instr_op_i; n.a = instr_addrA_i;
                n.b = instr_addrB_i; n.c = instr_addrC_i;
                n.s = instr_scalar_i; n.w = instr_wdata_i;
                mq.push_back(n);
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [AW-1:0] a,
        input logic [AW-1:0] b, input logic [AW-1:0] c,
        input logic [DW-1:0] s, input logic [DW-1:0] w);
        bit ok;
        ok = 0;
        instr_v_i = 1; instr_op_i = op;
        instr_addrA_i = a; instr_addrB_i = b; instr_addrC_i = c;
        instr_scalar_i = s; instr_wdata_i = w;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = instr_ready_o;
            @(posedge clk);
            #1;
        end
        instr_v_i = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: op %h never accepted", op);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            idle = (busy_o == 1'b0);
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy stuck at 1, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic yumi_pulse();
        res_yumi_i = 1;
        @(posedge clk);
        #1;
        res_yumi_i = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1; instr_v_i = 0; instr_op_i = '0;
        instr_addrA_i = '0; instr_addrB_i = '0; instr_addrC_i = '0;
        instr_scalar_i = '0; instr_wdata_i = '0;
        vec_ready_i = 0; res_yumi_i = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 0;
        started = 1;
        @(negedge clk);
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_vec_v", vec_v_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cnt", done_count_o, 0);
        @(posedge clk);
        #1;

        // 1: writes, vector add, read
        vec_ready_i = 1; done_dly = 1; rd_dly = 0;
        push(4'b1001, 0, 0, 1, 0, 16'h0101);
        push(4'b1001, 0, 0, 2, 0, 16'h1144);
        push(4'b0000, 1, 2, 0, 0, 0);
        push(4'b1000, 0, 0, 0, 0, 0);
        wait_idle();
        @(negedge clk);
        chk("t1_data", res_data_o, 16'h1245);
        chk("t1_addr", res_addr_o, 0);
        chk("t1_cnt", done_count_o, 4);
        @(posedge clk);
        #1;
        yumi_pulse();

        // 2: sub, mul, vec-scalar add with varied data/done order
        done_dly = 0; rd_dly = 2;
        push(4'b0001, 2, 1, 3, 0, 0);
        push(4'b1000, 3, 0, 0, 0, 0);
        wait_idle();
        @(negedge clk);
        chk("t2_sub", res_data_o, 16'h1043);
        @(posedge clk);
        #1;
        yumi_pulse();
        done_dly = 2; rd_dly = 2;
        push(4'b0010, 1, 3, 5, 0, 0);
        push(4'b1000, 5, 0, 0, 0, 0);
        wait_idle();
        @(negedge clk);
        chk("t2_mul", res_data_o, 16'h0003);
        chk("t2_mul_addr", res_addr_o, 5);
        @(posedge clk);
        #1;
        yumi_pulse();
        done_dly = 3; rd_dly = 0;
        push(4'b0100, 1, 0, 6, 16'h1111, 0);
        push(4'b1000, 6, 0, 0, 0, 0);
        wait_idle();
        @(negedge clk);
        chk("t2_vs", res_data_o, 16'h1212);
        chk("t2_cnt", done_count_o, 10);
        @(posedge clk);
        #1;
        yumi_pulse();

        // 3: backpressure from core, FIFO fills
        vec_ready_i = 0; done_dly = 1;
        for (int k = 0; k < 4; k++)
            push(4'b1001, 0, 0, 7, 0, 16'h7000 + 16'(k));
        @(negedge clk);
        chk("t3_full", instr_ready_o, 0);
        chk("t3_vec_v", vec_v_o, 1);
        @(posedge clk);
        #1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                vec_ready_i = 1;
            end
        join_none
        push(4'b1001, 0, 0, 7, 0, 16'h7004);
        wait_idle();
        @(negedge clk);
        chk("t3_cnt", done_count_o, 15);
        @(posedge clk);
        #1;

        // 4: illegal op dropped, sticky error
        push(4'b0011, 1, 2, 4, 0, 0);
        push(4'b1001, 0, 0, 4, 0, 16'hABCD);
        wait_idle();
        @(negedge clk);
        chk("t4_err", err_o, 1);
        chk("t4_cnt", done_count_o, 16);
        @(posedge clk);
        #1;

        // 5: second read stalls on a full result buffer
        done_dly = 0; rd_dly = 1;
        push(4'b1000, 1, 0, 0, 0, 0);
        push(4'b1000, 2, 0, 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_hold_data", res_data_o, 16'h0101);
        chk("t5_hold_yumi", vec_yumi_o, 0);
        chk("t5_hold_busy", busy_o, 1);
        chk("t5_hold_cnt", done_count_o, 17);
        @(posedge clk);
        #1;
        yumi_pulse();
        wait_idle();
        @(negedge clk);
        chk("t5_data", res_data_o, 16'h1144);
        chk("t5_addr", res_addr_o, 2);
        chk("t5_cnt", done_count_o, 18);
        chk("t5_err", err_o, 1);
        @(posedge clk);
        #1;

        // 6: reset while waiting with queued work
        done_dly = 6; rd_dly = 0;
        push(4'b1001, 0, 0, 0, 0, 16'h0AAA);
        push(4'b1001, 0, 0, 1, 0, 16'h0BBB);
        push(4'b1001, 0, 0, 2, 0, 16'h0CCC);
        reset_i = 1;
        @(posedge clk);
        #1;
        reset_i = 0;
        @(negedge clk);
        chk("t6_busy", busy_o, 0);
        chk("t6_vec_v", vec_v_o, 0);
        chk("t6_res_v", res_v_o, 0);
        chk("t6_cnt", done_count_o, 0);
        chk("t6_ready", instr_ready_o, 1);
        chk("t6_err", err_o, 0);
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_late_cnt", done_count_o, 0);
        chk("t6_late_busy", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
